// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types plus the RAM arbiter's grant bookkeeping.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    // Core-id width is fixed here; arbiter instances are expected to use ARB_CPUS cores.
    localparam int ARB_CPUS = 2;
    localparam int ARB_ID_W = (ARB_CPUS > 1) ? $clog2(ARB_CPUS) : 1;
    typedef logic [ARB_ID_W-1:0] coreId_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef enum logic {ICLASS, DCLASS} arb_class_t;

    typedef struct packed {
        arb_class_t cls;
        coreId_t    id;
    } grant_t;

    function automatic coreId_t nextId(coreId_t id, int cpus);
        if (int'(id) >= cpus - 1) return '0;
        return id + 1'b1;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response arrays and the single RAM port, bundled for the arbiter.
interface mem_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import cpu_types_pkg::*;

    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0][ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][ADDR_W-1:0] daddr;
    logic [CPUS-1:0][DATA_W-1:0] dstore;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][DATA_W-1:0] iload;
    logic [CPUS-1:0][DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo CPUS.
module rr_picker #(
    parameter int CPUS = 2,
    parameter int ID_W = 1
) (
    input  logic [CPUS-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);
    int cand;

    // Scan farthest-first so the nearest pending requester is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % CPUS;
            if (req[ID_W'(cand)]) begin
                valid = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM among every core's icache and dcache: dcache first, round-robin per class.
// state | meaning
// IDLE  | sample requests, register the winner; no RAM enables driven
// GRANT | winner drives the RAM until ACCESS, ERROR, or it drops its request
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = ARB_CPUS,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus,
    output logic         memerr
);
    arb_state_t state, nextState;
    grant_t     grant, nextGrant;
    coreId_t    iPtr, dPtr, nextIPtr, nextDPtr;
    logic       nextMemerr;

    logic            iValid, dValid;
    coreId_t         iIdx, dIdx;
    logic [CPUS-1:0] dReq;
    logic            reqLive;

    logic [CPUS-1:0]   iwait, dwait;
    logic              ramREN, ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;

    assign dReq = bus.dREN | bus.dWEN;

    rr_picker #(.CPUS(CPUS), .ID_W(ARB_ID_W)) dPicker (
        .req(dReq), .ptr(dPtr), .valid(dValid), .idx(dIdx)
    );

    rr_picker #(.CPUS(CPUS), .ID_W(ARB_ID_W)) iPicker (
        .req(bus.iREN), .ptr(iPtr), .valid(iValid), .idx(iIdx)
    );

    assign reqLive = (grant.cls == DCLASS) ? dReq[grant.id] : bus.iREN[grant.id];

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state  <= IDLE;
            grant  <= '{cls: ICLASS, id: '0};
            iPtr   <= '0;
            dPtr   <= '0;
            memerr <= 1'b0;
        end else begin
            state  <= nextState;
            grant  <= nextGrant;
            iPtr   <= nextIPtr;
            dPtr   <= nextDPtr;
            memerr <= nextMemerr;
        end
    end

    // Outputs are gated by reset so an in-flight grant aborts without a completion pulse.
    always_comb begin
        nextState  = state;
        nextGrant  = grant;
        nextIPtr   = iPtr;
        nextDPtr   = dPtr;
        nextMemerr = memerr;
        iwait      = '1;
        dwait      = '1;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        if (!nRST) begin
            case (state)
                IDLE: begin
                    if (dValid) begin
                        nextGrant = '{cls: DCLASS, id: dIdx};
                        nextState = GRANT;
                    end else if (iValid) begin
                        nextGrant = '{cls: ICLASS, id: iIdx};
                        nextState = GRANT;
                    end
                end
                GRANT: begin
                    if (!reqLive) begin
                        nextState = IDLE;
                    end else begin
                        if (grant.cls == DCLASS) begin
                            ramaddr  = bus.daddr[grant.id];
                            ramstore = bus.dstore[grant.id];
                            ramWEN   = bus.dWEN[grant.id];
                            ramREN   = !bus.dWEN[grant.id];
                        end else begin
                            ramaddr = bus.iaddr[grant.id];
                            ramREN  = 1'b1;
                        end
                        case (bus.ramstate)
                            ACCESS: begin
                                nextState = IDLE;
                                if (grant.cls == DCLASS) begin
                                    dwait[grant.id] = 1'b0;
                                    nextDPtr        = nextId(grant.id, CPUS);
                                end else begin
                                    iwait[grant.id] = 1'b0;
                                    nextIPtr        = nextId(grant.id, CPUS);
                                end
                            end
                            ERROR: begin
                                nextMemerr = 1'b1;
                                nextState  = IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    assign bus.iwait    = iwait;
    assign bus.dwait    = dwait;
    assign bus.iload    = {CPUS{bus.ramload}};
    assign bus.dload    = {CPUS{bus.ramload}};
    assign bus.ramREN   = ramREN;
    assign bus.ramWEN   = ramWEN;
    assign bus.ramaddr  = ramaddr;
    assign bus.ramstore = ramstore;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single transactions plus corner-case sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int IW   = 1;

    logic CLK;
    logic nRST;
    logic memerr;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.CPUS(CPUS), .ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.CPUS(CPUS), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .memerr(memerr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit          isD;
        int          id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          isD;
        int          id;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          busy;
        bit          expREN;
        bit          expWEN;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expectDone(input bit isD, input int id, input logic [31:0] data);
        exp_t e;
        e.isD  = isD;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic setReq(input bit isD, input int id, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] data);
        if (isD) begin
            bus.dREN[IW'(id)]   = rd;
            bus.dWEN[IW'(id)]   = wr;
            bus.daddr[IW'(id)]  = addr;
            bus.dstore[IW'(id)] = data;
        end else begin
            bus.iREN[IW'(id)]  = rd;
            bus.iaddr[IW'(id)] = addr;
        end
    endtask

    task automatic complete(input bit isD, input int c, input logic [31:0] load);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected %s%0d completed with load=%h, required no completion",
                     isD ? "dcache" : "icache", c, load);
        end else begin
            e = sb.pop_front();
            check("sb_class", 32'(isD), 32'(e.isD));
            check("sb_id", c, e.id);
            check("sb_load", load, e.data);
        end
    endtask

    // Completion monitor: every low wait must match the oldest expected completion.
    initial begin
        forever begin
            @(negedge CLK);
            for (int c = 0; c < CPUS; c++) begin
                if (bus.iwait[IW'(c)] === 1'b0) complete(1'b0, c, bus.iload[IW'(c)]);
                if (bus.dwait[IW'(c)] === 1'b0) complete(1'b1, c, bus.dload[IW'(c)]);
            end
        end
    end

    initial begin
        vecs[0] = '{isD: 1'b0, id: 0, rd: 1'b1, wr: 1'b0, addr: 32'h40,  data: 32'hDEADBEEF, busy: 1, expREN: 1'b1, expWEN: 1'b0};
        vecs[1] = '{isD: 1'b0, id: 1, rd: 1'b1, wr: 1'b0, addr: 32'h44,  data: 32'h11111111, busy: 0, expREN: 1'b1, expWEN: 1'b0};
        vecs[2] = '{isD: 1'b1, id: 0, rd: 1'b1, wr: 1'b0, addr: 32'h100, data: 32'hA5A5A5A5, busy: 2, expREN: 1'b1, expWEN: 1'b0};
        vecs[3] = '{isD: 1'b1, id: 1, rd: 1'b0, wr: 1'b1, addr: 32'h80,  data: 32'h00001234, busy: 0, expREN: 1'b0, expWEN: 1'b1};
        vecs[4] = '{isD: 1'b1, id: 0, rd: 1'b0, wr: 1'b1, addr: 32'h200, data: 32'hCAFEF00D, busy: 3, expREN: 1'b0, expWEN: 1'b1};
        vecs[5] = '{isD: 1'b1, id: 1, rd: 1'b1, wr: 1'b1, addr: 32'h204, data: 32'h0BADF00D, busy: 1, expREN: 1'b0, expWEN: 1'b1};

        nRST         = 1'b1;
        bus.iREN     = '1;
        bus.dREN     = '1;
        bus.dWEN     = '0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;

        // Reset with every request asserted
        repeat (2) @(posedge CLK);
        #1;
        check("rst_iwait", 32'(bus.iwait), 32'h3);
        check("rst_dwait", 32'(bus.dwait), 32'h3);
        check("rst_ramREN", 32'(bus.ramREN), 0);
        check("rst_ramWEN", 32'(bus.ramWEN), 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_memerr", 32'(memerr), 0);
        nRST     = 1'b0;
        bus.iREN = '0;
        bus.dREN = '0;
        tick();

        // Single-requester transactions
        for (int v = 0; v < 6; v++) begin
            setReq(vecs[v].isD, vecs[v].id, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data);
            #1;
            check($sformatf("vec%0d_idle_en", v), 32'({bus.ramREN, bus.ramWEN}), 0);
            tick();
            for (int b = 0; b <= vecs[v].busy; b++) begin
                if (b == vecs[v].busy) begin
                    bus.ramstate = ACCESS;
                    bus.ramload  = vecs[v].data;
                    expectDone(vecs[v].isD, vecs[v].id, vecs[v].data);
                end else begin
                    bus.ramstate = BUSY;
                end
                #1;
                check($sformatf("vec%0d_ramREN", v), 32'(bus.ramREN), 32'(vecs[v].expREN));
                check($sformatf("vec%0d_ramWEN", v), 32'(bus.ramWEN), 32'(vecs[v].expWEN));
                check($sformatf("vec%0d_ramaddr", v), bus.ramaddr, vecs[v].addr);
                if (vecs[v].wr) check($sformatf("vec%0d_ramstore", v), bus.ramstore, vecs[v].data);
                tick();
            end
            setReq(vecs[v].isD, vecs[v].id, 1'b0, 1'b0, vecs[v].addr, vecs[v].data);
            bus.ramstate = FREE;
        end

        // Priority: dcache1 write beats icache0 read
        setReq(1'b0, 0, 1'b1, 1'b0, 32'h300, 32'h0);
        setReq(1'b1, 1, 1'b0, 1'b1, 32'h80, 32'h1234);
        #1;
        check("pri_idle_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h5555AAAA;
        expectDone(1'b1, 1, 32'h5555AAAA);
        #1;
        check("pri_d_ramWEN", 32'(bus.ramWEN), 1);
        check("pri_d_ramREN", 32'(bus.ramREN), 0);
        check("pri_d_ramaddr", bus.ramaddr, 32'h80);
        check("pri_d_ramstore", bus.ramstore, 32'h1234);
        tick();
        setReq(1'b1, 1, 1'b0, 1'b0, 32'h80, 32'h1234);
        bus.ramstate = FREE;
        #1;
        check("pri_gap_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h30303030;
        expectDone(1'b0, 0, 32'h30303030);
        #1;
        check("pri_i_ramREN", 32'(bus.ramREN), 1);
        check("pri_i_ramaddr", bus.ramaddr, 32'h300);
        tick();
        setReq(1'b0, 0, 1'b0, 1'b0, 32'h300, 32'h0);
        bus.ramstate = FREE;

        // Round-robin: both dcaches hold dREN with immediate ACCESS
        setReq(1'b1, 0, 1'b1, 1'b0, 32'h500, 32'h0);
        setReq(1'b1, 1, 1'b1, 1'b0, 32'h600, 32'h0);
        bus.ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.ramload = 32'h1000 + k;
            expectDone(1'b1, k % 2, 32'h1000 + k);
            #1;
            check($sformatf("rr%0d_ramaddr", k), bus.ramaddr, (k % 2 == 1) ? 32'h600 : 32'h500);
            tick();
            #1;
            check($sformatf("rr%0d_gap_en", k), 32'({bus.ramREN, bus.ramWEN}), 0);
        end
        bus.dREN     = '0;
        bus.ramstate = FREE;

        // Abort: icache1 drops its request mid-grant, pointer must stay on core1
        setReq(1'b0, 1, 1'b1, 1'b0, 32'h700, 32'h0);
        bus.ramstate = BUSY;
        tick();
        #1;
        check("ab_ramREN", 32'(bus.ramREN), 1);
        check("ab_ramaddr", bus.ramaddr, 32'h700);
        tick();
        setReq(1'b0, 1, 1'b0, 1'b0, 32'h700, 32'h0);
        #1;
        check("ab_drop_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        tick();
        setReq(1'b0, 0, 1'b1, 1'b0, 32'h704, 32'h0);
        setReq(1'b0, 1, 1'b1, 1'b0, 32'h700, 32'h0);
        #1;
        check("ab_idle_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h00000077;
        expectDone(1'b0, 1, 32'h00000077);
        #1;
        check("ab_ptr_ramaddr", bus.ramaddr, 32'h700);
        tick();
        setReq(1'b0, 1, 1'b0, 1'b0, 32'h700, 32'h0);
        bus.ramstate = FREE;
        #1;
        check("ab_gap_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h00000078;
        expectDone(1'b0, 0, 32'h00000078);
        #1;
        check("ab_next_ramaddr", bus.ramaddr, 32'h704);
        tick();
        setReq(1'b0, 0, 1'b0, 1'b0, 32'h704, 32'h0);
        bus.ramstate = FREE;

        // Error during a dcache0 read, then retry completes
        check("err_memerr_pre", 32'(memerr), 0);
        setReq(1'b1, 0, 1'b1, 1'b0, 32'h900, 32'h0);
        tick();
        bus.ramstate = ERROR;
        #1;
        check("err_ramREN", 32'(bus.ramREN), 1);
        check("err_dwait", 32'(bus.dwait), 32'h3);
        tick();
        bus.ramstate = FREE;
        #1;
        check("err_memerr", 32'(memerr), 1);
        check("err_idle_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h00009999;
        expectDone(1'b1, 0, 32'h00009999);
        #1;
        check("err_retry_ramaddr", bus.ramaddr, 32'h900);
        tick();
        setReq(1'b1, 0, 1'b0, 1'b0, 32'h900, 32'h0);
        bus.ramstate = FREE;
        repeat (3) tick();
        check("err_memerr_sticky", 32'(memerr), 1);

        // Reset asserted mid-grant with ACCESS: no completion, enables drop at once
        setReq(1'b1, 1, 1'b1, 1'b0, 32'hA00, 32'h0);
        tick();
        bus.ramstate = ACCESS;
        nRST         = 1'b1;
        #1;
        check("rstg_en", 32'({bus.ramREN, bus.ramWEN}), 0);
        check("rstg_dwait", 32'(bus.dwait), 32'h3);
        tick();
        check("rstg_memerr", 32'(memerr), 0);
        nRST = 1'b0;
        setReq(1'b1, 1, 1'b0, 1'b0, 32'hA00, 32'h0);
        bus.ramstate = FREE;
        repeat (2) tick();
        #1;
        check("rstg_idle_en", 32'({bus.ramREN, bus.ramWEN}), 0);

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
